score_display_scan: RTL and testbench

Sequential driver that takes the three BCD score digits (ones/tens/hundreds) from the binary-to-BCD converter and time-multiplexes them onto a 4-digit common-anode seven-segment display. A fourth digit shows an auxiliary hex nibble, such as level or lives.

---
 rtl/seg7_pkg.sv | 44 ++++
 rtl/seg7_decode.sv | 35 +++
 rtl/score_display_scan.sv | 132 +++++++++++++
 tb/tb_score_display_scan.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyphs {g,f,e,d,c,b,a},
// anode/segment idle patterns, slot enumeration and the packed digit record.
package seg7_pkg;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_A    = 7'b0001000;
   localparam logic [6:0] SEG_B    = 7'b0000011;
   localparam logic [6:0] SEG_C    = 7'b1000110;
   localparam logic [6:0] SEG_D    = 7'b0100001;
   localparam logic [6:0] SEG_E    = 7'b0000110;
   localparam logic [6:0] SEG_F    = 7'b0001110;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [3:0] AN_OFF   = 4'b1111;

   typedef enum logic [1:0] {
      SLOT_ONE     = 2'd0,
      SLOT_TEN     = 2'd1,
      SLOT_HUNDRED = 2'd2,
      SLOT_AUX     = 2'd3
   } slot_e;

   typedef struct packed {
      logic [3:0] aux;
      logic [3:0] hundred;
      logic [3:0] ten;
      logic [3:0] one;
   } digits_t;

   // Active-low one-hot anode for a slot; slot 0 is the rightmost digit.
   function automatic logic [3:0] an_for_slot(input slot_e slot);
      return ~(4'b0001 << slot);
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low seven-segment glyph. In BCD mode codes 10-15 render
// as a dash so a corrupted score is visible rather than misleading.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] value_i,
   input  logic       hex_mode_i,
   output logic [6:0] seg_o
);

   // NOTE: a default assignment first keeps every path driven, so no latch.
   always_comb begin
      seg_o = SEG_DASH;
      case (value_i)
         4'h0: seg_o = SEG_0;
         4'h1: seg_o = SEG_1;
         4'h2: seg_o = SEG_2;
         4'h3: seg_o = SEG_3;
         4'h4: seg_o = SEG_4;
         4'h5: seg_o = SEG_5;
         4'h6: seg_o = SEG_6;
         4'h7: seg_o = SEG_7;
         4'h8: seg_o = SEG_8;
         4'h9: seg_o = SEG_9;
         4'hA: seg_o = hex_mode_i ? SEG_A : SEG_DASH;
         4'hB: seg_o = hex_mode_i ? SEG_B : SEG_DASH;
         4'hC: seg_o = hex_mode_i ? SEG_C : SEG_DASH;
         4'hD: seg_o = hex_mode_i ? SEG_D : SEG_DASH;
         4'hE: seg_o = hex_mode_i ? SEG_E : SEG_DASH;
         4'hF: seg_o = hex_mode_i ? SEG_F : SEG_DASH;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/score_display_scan.sv
// Four-digit common-anode scan driver: three BCD score digits plus an aux hex
// nibble, with frame-aligned update staging, leading-zero blanking and dead-time.
module score_display_scan
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int DEAD_CYCLES = 16,
   parameter int CNT_W       = 17
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] one,
   input  logic [3:0] ten,
   input  logic [3:0] hundred,
   input  logic [3:0] aux,
   input  logic       aux_en,
   input  logic       update,
   input  logic       blank_lz,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   slot_e            idx_q, idx_d;
   digits_t          stage_q, stage_d;
   digits_t          disp_q, disp_d;
   logic             pending_q, pending_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;

   logic             tick;
   logic             frame_end;
   logic             dead;
   digits_t          port_digits;
   logic [3:0]       slot_val;
   logic             slot_blank;
   logic             hex_mode;
   logic [6:0]       dec_seg;

   assign tick        = (cnt_q == CNT_W'(REFRESH_DIV - 1));
   assign frame_end   = tick && (idx_q == SLOT_AUX);
   assign dead        = (cnt_q < CNT_W'(DEAD_CYCLES));
   assign port_digits = {aux, hundred, ten, one};

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      idx_d = tick ? slot_e'(idx_q + 2'd1) : idx_q;
   end

   // The display registers only ever change at the last tick of a frame.
   always_comb begin
      stage_d   = stage_q;
      disp_d    = disp_q;
      pending_d = pending_q;
      if (frame_end) begin
         pending_d = 1'b0;
         if (update) begin
            disp_d = port_digits;
         end else if (pending_q) begin
            disp_d = stage_q;
         end
      end else if (update) begin
         stage_d   = port_digits;
         pending_d = 1'b1;
      end
   end

   always_comb begin
      slot_val   = disp_q.one;
      slot_blank = 1'b0;
      hex_mode   = 1'b0;
      case (idx_q)
         SLOT_ONE: begin
            slot_val = disp_q.one;
         end
         SLOT_TEN: begin
            slot_val   = disp_q.ten;
            slot_blank = blank_lz && (disp_q.hundred == 4'd0) && (disp_q.ten == 4'd0);
         end
         SLOT_HUNDRED: begin
            slot_val   = disp_q.hundred;
            slot_blank = blank_lz && (disp_q.hundred == 4'd0);
         end
         SLOT_AUX: begin
            slot_val   = disp_q.aux;
            hex_mode   = 1'b1;
            slot_blank = !aux_en;
         end
         default: ;
      endcase
   end

   seg7_decode u_decode (
      .value_i    (slot_val),
      .hex_mode_i (hex_mode),
      .seg_o      (dec_seg)
   );

   // Dead-time gates only the anodes; segments settle early on the new glyph.
   always_comb begin
      an_d  = (slot_blank || dead) ? AN_OFF : an_for_slot(idx_q);
      seg_d = slot_blank ? SEG_OFF : dec_seg;
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         idx_q     <= SLOT_ONE;
         stage_q   <= '0;
         disp_q    <= '0;
         pending_q <= 1'b0;
         an_q      <= AN_OFF;
         seg_q     <= SEG_OFF;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         stage_q   <= stage_d;
         disp_q    <= disp_d;
         pending_q <= pending_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display_scan.sv
// Directed bench for score_display_scan: table of digit sets with hand-derived
// per-slot glyphs, plus sequences for tear-free, coincident and mid-frame reset.
module tb_score_display_scan;

   localparam int RD    = 8;
   localparam int DC    = 2;
   localparam int FRAME = 4 * RD;

   localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30;
   localparam logic [6:0] G4 = 7'h19, G5 = 7'h12, G7 = 7'h78, G8 = 7'h00;
   localparam logic [6:0] G9 = 7'h10, GA = 7'h08, GB = 7'h03, GF = 7'h0E;
   localparam logic [6:0] GD = 7'h3F, GO = 7'h7F;

   typedef struct packed {
      logic [3:0] aux;
      logic [3:0] hundred;
      logic [3:0] ten;
      logic [3:0] one;
   } din_t;

   typedef struct packed {
      logic [3:0][3:0] an;
      logic [3:0][6:0] seg;
   } exp_t;

   typedef struct {
      din_t d;
      logic blz;
      logic aen;
      exp_t e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] one, ten, hundred, aux;
   logic       aux_en, update, blank_lz;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   score_display_scan #(
      .REFRESH_DIV (RD),
      .DEAD_CYCLES (DC),
      .CNT_W       (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .one      (one),
      .ten      (ten),
      .hundred  (hundred),
      .aux      (aux),
      .aux_en   (aux_en),
      .update   (update),
      .blank_lz (blank_lz),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   function automatic exp_t mk(input logic [3:0] a0, input logic [6:0] s0,
                               input logic [3:0] a1, input logic [6:0] s1,
                               input logic [3:0] a2, input logic [6:0] s2,
                               input logic [3:0] a3, input logic [6:0] s3);
      exp_t e;
      e.an[0] = a0; e.seg[0] = s0;
      e.an[1] = a1; e.seg[1] = s1;
      e.an[2] = a2; e.seg[2] = s2;
      e.an[3] = a3; e.seg[3] = s3;
      return e;
   endfunction

   function automatic din_t mkd(input logic [3:0] a, input logic [3:0] h,
                                input logic [3:0] t, input logic [3:0] o);
      din_t d;
      d.aux = a; d.hundred = h; d.ten = t; d.one = o;
      return d;
   endfunction

   // Expected {dp, an, seg} for frame position s: anodes dark in the dead cycles.
   function automatic logic [11:0] exp_at(input exp_t e, input int s);
      int slot;
      int ph;
      slot = s / RD;
      ph   = s % RD;
      return {1'b1, (ph < DC) ? 4'hF : e.an[slot], e.seg[slot]};
   endfunction

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got dp/an/seg=%b/%b/%b want %b/%b/%b",
                    name, act[11], act[10:7], act[6:0], want[11], want[10:7], want[6:0]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ports(input din_t d);
      one = d.one; ten = d.ten; hundred = d.hundred; aux = d.aux;
   endtask

   // One full frame of 32 checked cycles; optional update pulses at positions ua/ub.
   task automatic run_frame(input exp_t e, input string tag,
                            input int ua, input din_t da, input int ub, input din_t db);
      for (int s = 0; s < FRAME; s++) begin
         update = 1'b0;
         if (s == ua) begin
            set_ports(da);
            update = 1'b1;
         end else if (s == ub) begin
            set_ports(db);
            update = 1'b1;
         end
         tick();
         check($sformatf("%s s%0d", tag, s), {dp, an, seg}, exp_at(e, s));
      end
      update = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[7];
      exp_t prev, e_zero, e_987, e_y, e_yb, e_z0;
      din_t none_d;

      none_d = mkd(4'h0, 4'h0, 4'h0, 4'h0);
      e_zero = mk(4'hE, G0, 4'hD, G0, 4'hB, G0, 4'hF, GO);
      vecs[0] = '{mkd(4'h0, 4'h1, 4'h2, 4'h3), 1'b0, 1'b0, mk(4'hE, G3, 4'hD, G2, 4'hB, G1, 4'hF, GO)};
      vecs[1] = '{mkd(4'h0, 4'h0, 4'h0, 4'h7), 1'b1, 1'b0, mk(4'hE, G7, 4'hF, GO, 4'hF, GO, 4'hF, GO)};
      vecs[2] = '{mkd(4'h0, 4'h0, 4'h5, 4'h0), 1'b1, 1'b0, mk(4'hE, G0, 4'hD, G5, 4'hF, GO, 4'hF, GO)};
      vecs[3] = '{mkd(4'h0, 4'h0, 4'h0, 4'h0), 1'b1, 1'b0, mk(4'hE, G0, 4'hF, GO, 4'hF, GO, 4'hF, GO)};
      vecs[4] = '{mkd(4'hA, 4'h0, 4'h9, 4'hC), 1'b0, 1'b1, mk(4'hE, GD, 4'hD, G9, 4'hB, G0, 4'h7, GA)};
      vecs[5] = '{mkd(4'hF, 4'hE, 4'h4, 4'h8), 1'b1, 1'b1, mk(4'hE, G8, 4'hD, G4, 4'hB, GD, 4'h7, GF)};
      vecs[6] = '{mkd(4'hB, 4'h0, 4'h0, 4'h1), 1'b0, 1'b1, mk(4'hE, G1, 4'hD, G0, 4'hB, G0, 4'h7, GB)};
      e_987 = mk(4'hE, G7, 4'hD, G8, 4'hB, G9, 4'h7, GB);
      e_y   = mk(4'hE, G2, 4'hD, G4, 4'hB, G0, 4'h7, GB);
      e_yb  = mk(4'hE, G2, 4'hD, G4, 4'hF, GO, 4'hF, GO);
      e_z0  = mk(4'hE, G0, 4'hF, GO, 4'hF, GO, 4'hF, GO);

      rst = 1'b1; update = 1'b0; blank_lz = 1'b0; aux_en = 1'b0;
      set_ports(none_d);
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("reset c%0d", c), {dp, an, seg}, 12'hFFF);
      end
      rst = 1'b0;

      run_frame(e_zero, "first_frame", -1, none_d, -1, none_d);

      // Each vector: stage mid-frame (old frame must not change), then check new frame.
      prev = e_zero;
      for (int i = 0; i < 7; i++) begin
         run_frame(prev, $sformatf("vec%0d_old", i), 5, vecs[i].d, -1, none_d);
         blank_lz = vecs[i].blz;
         aux_en   = vecs[i].aen;
         run_frame(vecs[i].e, $sformatf("vec%0d_new", i), -1, none_d, -1, none_d);
         prev = vecs[i].e;
      end

      run_frame(prev, "tear_cur", 10, mkd(4'hB, 4'h6, 4'h5, 4'h4), 20, mkd(4'hB, 4'h9, 4'h8, 4'h7));
      run_frame(e_987, "tear_next", -1, none_d, -1, none_d);

      // Staged X mid-frame, then Y exactly on the boundary tick: Y must win outright.
      run_frame(e_987, "coinc_pre", 12, mkd(4'hB, 4'h1, 4'h2, 4'h3), 31, mkd(4'hB, 4'h0, 4'h4, 4'h2));
      run_frame(e_y, "coinc_next", -1, none_d, -1, none_d);
      run_frame(e_y, "coinc_hold", -1, none_d, -1, none_d);

      blank_lz = 1'b1;
      aux_en   = 1'b0;
      run_frame(e_yb, "live_blank", -1, none_d, -1, none_d);

      for (int s = 0; s <= 20; s++) begin
         update = 1'b0;
         if (s == 5) begin
            set_ports(mkd(4'hB, 4'h3, 4'h3, 4'h3));
            update = 1'b1;
         end
         if (s == 20) rst = 1'b1;
         tick();
         if (s < 20) check($sformatf("midrst_pre s%0d", s), {dp, an, seg}, exp_at(e_yb, s));
         else        check("midrst_reset", {dp, an, seg}, 12'hFFF);
      end
      rst    = 1'b0;
      update = 1'b0;
      run_frame(e_z0, "midrst_after", -1, none_d, -1, none_d);
      run_frame(e_z0, "midrst_discard", -1, none_d, -1, none_d);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
